imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Writer side of the instruction memory: accepts a stream of 32-bit instruction words over a valid/ready port.
// - Writes them to consecutive word addresses of an internal RAM.
// - Serves the CPU's combinational word-aligned fetch port (a -> rd).
// - Holds the CPU in reset until the program is loaded. Sits between the bench or boot source and the single-cycle core's fetch path.
// PARAMETERS
// - DEPTH  64  number of 32-bit words; power of two, >= 2
// - AW     $clog2(DEPTH)  word-index width (derived, localparam)
// PORTS
// - clk         in   1   single clock, all state updates on posedge
// - reset       in   1   synchronous, active-high
// - ld_valid    in   1   ld_data/ld_last are valid this cycle
// - ld_ready    out  1   loader accepts a word this cycle
// - ld_data     in   32  instruction word
// - ld_last     in   1   this word is the final word of the program
// - ld_restart  in   1   one-cycle pulse: begin a new load at word 0
// - a           in   32  CPU fetch byte address
// - rd          out  32  instruction at word a[AW+1:2]
// - cpu_reset   out  1   1 while loading; drives core reset
// - load_done   out  1   1 once load completed (normally or by overflow)
// - load_err    out  1   1 if DEPTH words accepted without ld_last
// - load_count  out  AW+1  number of words written in current load
// BEHAVIOUR
// - Reset is synchronous and active-high on clk. Reset values: state=LOAD, ptr=0, load_count=0, load_done=0, load_err=0.
//   - Outputs at reset: cpu_reset=1, ld_ready=1 (unless ld_restart).
//   - RAM contents are not reset; unwritten words read undefined.
// - FSM states:
//   - LOAD: ld_ready = !ld_restart.
//   - DONE: ld_ready = 0.
// - Accept: ld_valid && ld_ready. At that posedge:
//   - RAM[ptr] <= ld_data; ptr++; load_count++.
// - LOAD -> DONE on an accepted word when:
//   - ld_last=1 (load_err stays 0), or
//   - ptr==DEPTH-1 with ld_last=0 (load_err <= 1). Words beyond DEPTH are never written; ptr never wraps.
// - ld_last with DEPTH-1 accepted words is a normal completion, not an error.
// - ld_restart (any state) at posedge: state=LOAD, ptr=0, load_count=0, load_done=0, load_err=0. RAM is untouched.
//   - Restart has priority over an accept in the same cycle: ld_ready=0, so that word is not accepted.
// - cpu_reset = (state==LOAD); load_done = (state==DONE). Both are registered state decodes, with no combinational path from ld_*.
// - cpu_reset deasserts the cycle after the last word is accepted, so the core's first fetch sees the complete program.
// - Read port is combinational at all times, including during LOAD (debug visibility).
//   - Index is a[AW+1:2]; a[1:0] and a[31:AW+2] are ignored, so upper addresses alias.
//   - A word written at posedge N is visible on rd after posedge N. A read of the same index in cycle N returns the old data.
// - ld_valid while ld_ready=0: no effect. The source must hold the word until ready.
// - ld_data and ld_last are don't-care when ld_valid=0.
// - Reset mid-load behaves as restart (ptr=0). Previously written words persist until overwritten.
// STRUCTURE
// - Package mem_pkg: typedef enum logic {LD_LOAD, LD_DONE} loader_state_t; localparam IMEM_DEPTH=64; localparam logic [31:0] NOP_INSTR=32'hE1A00000.
// - Sub-module imem_ram: one synchronous write port (we, waddr, wdata) and one async read port (raddr, rdata), DEPTH x 32.
//   - imem_loader holds the FSM, pointer, counters and handshake.
// TESTING
// 1 Basic load:
//   - Stimulus: stream EB000000, E2800008, E0411001, E2400008, ld_last on the 4th, ld_valid held high.
//   - Response: ld_ready=1 for 4 cycles, then load_done=1, cpu_reset=0, load_count=4, load_err=0.
//   - Reads: rd at a=0x0 is EB000000, a=0x4 is E2800008, a=0xC is E2400008, a=0x10C aliases to E2400008.
// 2 Backpressure/gaps:
//   - Stimulus: same 4 words with ld_valid toggled 1,0,1,0,... and one word held 3 cycles while in DONE.
//   - Response: exactly 4 writes, load_count=4; a word presented after DONE is never written (RAM[4] unchanged).
// 3 Overflow:
//   - Stimulus: 70 words 0x00000000..0x00000045, ld_last never set.
//   - Response: after the 64th accept, load_err=1, load_done=1, ld_ready=0, load_count=64. rd at a=0xFC is 0x0000003F.
// 4 Exact fill:
//   - Stimulus: 64 words with ld_last on the 64th.
//   - Response: load_err=0, load_done=1, load_count=64.
// 5 Restart priority:
//   - Stimulus: in DONE, ld_restart=1 and ld_valid=1 with data 12345678 in the same cycle.
//   - Response: no write, next cycle cpu_reset=1, load_count=0. Next accepted word (ld_last=1, data AAAA5555) lands at RAM[0]; RAM[1] keeps its old value.
// 6 Reset mid-load:
//   - Stimulus: after 2 of 4 words, reset=1 for 1 cycle, then reload 4 words.
//   - Response: ptr restarts at 0, load_count=4, and the final contents equal the second stream.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its RAM.
package mem_pkg;

  typedef enum logic {LD_LOAD = 1'b0, LD_DONE = 1'b1} loader_state_t;

  localparam int          IMEM_DEPTH = 64;
  localparam logic [31:0] NOP_INSTR  = 32'hE1A00000;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready load stream from the boot source into the instruction memory.
interface imem_loader_if;

  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_restart;

  modport master (output ld_valid, output ld_data, output ld_last, output ld_restart,
                  input  ld_ready);

  modport slave  (input  ld_valid, input  ld_data, input  ld_last, input  ld_restart,
                  output ld_ready);

endinterface

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction RAM: one synchronous write port, one asynchronous read port.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into the instruction RAM and holds the core in reset
// until the program has been loaded.
module imem_loader
  import mem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  imem_loader_if.slave             ld,
  input  logic [31:0]              a,
  output logic [31:0]              rd,
  output logic                     cpu_reset,
  output logic                     load_done,
  output logic                     load_err,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] S_LOAD = 1'(LD_LOAD);
  localparam logic [0:0] S_DONE = 1'(LD_DONE);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] ptr_q,   ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q,   err_d;
  logic          accept_s;
  logic          full_s;
  wire           unused_a = ^{a[31:AW+2], a[1:0]};

  // Restart steals the cycle, so a word offered alongside it is never taken.
  always_comb begin
    ld.ld_ready = (state_q == S_LOAD) && !ld.ld_restart;
  end

  assign accept_s = ld.ld_valid && ld.ld_ready && !reset;
  assign full_s   = (ptr_q == AW'(DEPTH - 1));

  // Next-state for the load FSM, write pointer, word counter and overflow flag.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    if (ld.ld_restart) begin
      state_d = S_LOAD;
      ptr_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept_s) begin
      count_d = count_q + (AW+1)'(1);
      ptr_d   = full_s ? ptr_q : ptr_q + AW'(1);
      if (ld.ld_last || full_s) begin
        state_d = S_DONE;
        err_d   = full_s && !ld.ld_last;
      end else begin
        state_d = S_LOAD;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign cpu_reset  = (state_q == S_LOAD);
  assign load_done  = (state_q == S_DONE);
  assign load_err   = err_q;
  assign load_count = count_q;

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept_s),
    .waddr (ptr_q),
    .wdata (ld.ld_data),
    .raddr (a[AW+1:2]),
    .rdata (rd)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed table, corner sequences, random vs model.
module tb_imem_loader;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] rd;
  logic        cpu_reset, load_done, load_err;
  logic [6:0]  load_count;

  imem_loader_if ldif ();

  imem_loader #(.DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (ldif.slave),
    .a          (a),
    .rd         (rd),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a word list indexed by arrival order within the current load.
  int          m_count;
  bit          m_done, m_err;
  logic [31:0] m_mem [64];
  bit          m_wr  [64];

  typedef struct {
    logic        rst, valid, last, restart;
    logic [31:0] data;
    logic        exp_ready;
    logic [6:0]  exp_count;
    logic        exp_done, exp_err;
  } vec_t;

  vec_t tbl [9];
  logic [31:0] w4 [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(name, rd, exp);
  endtask

  task automatic drive_cycle(input logic rst, input logic v, input logic l, input logic rs,
                             input logic [31:0] d, output logic rdy);
    logic        exp_rdy;
    int          pidx, ridx;
    logic [31:0] ra;
    reset = rst;
    ldif.ld_valid = v;
    ldif.ld_last = l;
    ldif.ld_restart = rs;
    ldif.ld_data = d;
    exp_rdy = !m_done && !rs;
    pidx = (m_count < 64) ? m_count : 63;
    a = {24'h0, 6'(pidx), 2'b00};
    #1;
    rdy = ldif.ld_ready;
    chk("ready", rdy, exp_rdy);
    if (m_wr[pidx]) chk("rd_before_write", rd, m_mem[pidx]);
    if (rst || rs) begin
      m_count = 0; m_done = 0; m_err = 0;
    end else if (v && exp_rdy) begin
      m_mem[m_count] = d;
      m_wr[m_count] = 1;
      m_count++;
      if (l) m_done = 1;
      else if (m_count == 64) begin m_done = 1; m_err = 1; end
    end
    @(posedge clk);
    #1;
    chk("cpu_reset", cpu_reset, !m_done);
    chk("load_done", load_done, m_done);
    chk("load_err", load_err, m_err);
    chk("load_count", load_count, m_count);
    ridx = $urandom_range(63, 0);
    ra = $urandom;
    ra[7:2] = 6'(ridx);
    a = ra;
    #1;
    if (m_wr[ridx]) chk("rd_random", rd, m_mem[ridx]);
  endtask

  initial begin
    logic rdy;
    for (int i = 0; i < 64; i++) m_wr[i] = 0;
    w4[0] = 32'hEB000000; w4[1] = 32'hE2800008; w4[2] = 32'hE0411001; w4[3] = 32'hE2400008;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hEB000000, 1'b1, 7'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hE2800008, 1'b1, 7'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hE0411001, 1'b1, 7'd3, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hE2400008, 1'b1, 7'd4, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 7'd4, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 7'd4, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 7'd4, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h12345678, 1'b0, 7'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA5555, 1'b1, 7'd1, 1'b1, 1'b0};

    reset = 1'b1;
    ldif.ld_valid = 1'b0; ldif.ld_last = 1'b0; ldif.ld_restart = 1'b0; ldif.ld_data = 32'h0;
    a = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    m_count = 0; m_done = 0; m_err = 0;
    chk("reset_cpu_reset", cpu_reset, 1'b1);
    chk("reset_load_done", load_done, 1'b0);
    chk("reset_load_err", load_err, 1'b0);
    chk("reset_load_count", load_count, 7'd0);
    chk("reset_ready", ldif.ld_ready, 1'b1);

    // Basic load, hold in DONE, then restart racing a valid word.
    for (int i = 0; i < 9; i++) begin
      drive_cycle(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].restart, tbl[i].data, rdy);
      chk($sformatf("tbl%0d_ready", i), rdy, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_count", i), load_count, tbl[i].exp_count);
      chk($sformatf("tbl%0d_done", i), load_done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_err", i), load_err, tbl[i].exp_err);
      if (i == 3) begin
        chk("basic_cpu_reset", cpu_reset, 1'b0);
        rd_chk("basic_rd0", 32'h0, 32'hEB000000);
        rd_chk("basic_rd4", 32'h4, 32'hE2800008);
        rd_chk("basic_rdC", 32'hC, 32'hE2400008);
        rd_chk("basic_alias", 32'h10C, 32'hE2400008);
      end
      if (i == 7) chk("restart_cpu_reset", cpu_reset, 1'b1);
    end
    rd_chk("restart_rd0", 32'h0, 32'hAAAA5555);
    rd_chk("restart_rd1_kept", 32'h4, 32'hE2800008);

    // Overflow: 70 words, ld_last never set.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, rdy);
    for (int i = 0; i < 70; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'(i), rdy);
      if (i == 63) begin
        chk("ovf_err", load_err, 1'b1);
        chk("ovf_done", load_done, 1'b1);
        chk("ovf_count", load_count, 7'd64);
        chk("ovf_ready", ldif.ld_ready, 1'b0);
      end
    end
    chk("ovf_count_final", load_count, 7'd64);
    rd_chk("ovf_rdFC", 32'hFC, 32'h0000003F);
    rd_chk("ovf_rd0", 32'h0, 32'h00000000);

    // Backpressure with gaps, then a word held while in DONE.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, rdy);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drive_cycle(1'b0, 1'b1, k == 6, 1'b0, w4[k/2], rdy);
      else            drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, $urandom, rdy);
    end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, rdy);
      chk("bp_held_ready", rdy, 1'b0);
    end
    chk("bp_count", load_count, 7'd4);
    rd_chk("bp_ram4_unchanged", 32'h10, 32'h00000004);
    for (int k = 0; k < 4; k++) rd_chk("bp_rd", 32'(k * 4), w4[k]);

    // Exact fill: ld_last on the 64th word.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, rdy);
    for (int i = 0; i < 64; i++) begin
      drive_cycle(1'b0, 1'b1, i == 63, 1'b0, 32'h1000 + 32'(i), rdy);
      if (i == 62) chk("fill_not_done", load_done, 1'b0);
    end
    chk("fill_err", load_err, 1'b0);
    chk("fill_done", load_done, 1'b1);
    chk("fill_count", load_count, 7'd64);
    rd_chk("fill_rdFC", 32'hFC, 32'h0000103F);

    // Reset in the middle of a load, then a full reload.
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, rdy);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h11, rdy);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h22, rdy);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, rdy);
    chk("rst_mid_count", load_count, 7'd0);
    chk("rst_mid_cpu_reset", cpu_reset, 1'b1);
    for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, k == 3, 1'b0, 32'hA0 + 32'(k), rdy);
    chk("rst_mid_reload_count", load_count, 7'd4);
    for (int k = 0; k < 4; k++) rd_chk("rst_mid_rd", 32'(k * 4), 32'hA0 + 32'(k));

    // Randomised traffic against the model, in three flavours of stream.
    for (int blk = 0; blk < 3; blk++) begin
      for (int c = 0; c < 1000; c++) begin
        logic r, rs, v, l;
        case (blk)
          0:       begin r = ($urandom_range(63, 0) == 0); rs = ($urandom_range(15, 0) == 0);
                         v = $urandom_range(1, 0) == 1;    l = ($urandom_range(7, 0) == 0); end
          1:       begin r = 1'b0; rs = ($urandom_range(199, 0) == 0);
                         v = $urandom_range(3, 0) != 0;    l = 1'b0; end
          default: begin r = ($urandom_range(127, 0) == 0); rs = ($urandom_range(40, 0) == 0);
                         v = $urandom_range(3, 0) != 0;    l = ($urandom_range(70, 0) == 0); end
        endcase
        drive_cycle(r, v, l, rs, $urandom, rdy);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
